// File: rtl/aec_pkg.sv
// Token encoding, FSM state type and operator helpers for the expression calculator.
// Optional feature macro: AEC_DIV_EN (adds '/' as an operator).
package aec_pkg;

  localparam int unsigned TOK_W = 5;
  typedef logic [TOK_W-1:0] tok_t;

  localparam tok_t TOK_LPAREN = 5'd16;
  localparam tok_t TOK_RPAREN = 5'd17;
  localparam tok_t TOK_MUL    = 5'd18;
  localparam tok_t TOK_ADD    = 5'd19;
  localparam tok_t TOK_SUB    = 5'd20;
  localparam tok_t TOK_DIV    = 5'd21;
  localparam tok_t TOK_EQ     = 5'd22;
  localparam tok_t TOK_ILL    = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_DONE
  } state_e;

  // ASCII to token; digits map to their value 0..15
  function automatic tok_t encode(input logic [7:0] c);
    tok_t t;
    t = TOK_ILL;
    if (c >= 8'h30 && c <= 8'h39) begin
      t = TOK_W'(c - 8'h30);
    end else if (c >= 8'h61 && c <= 8'h66) begin
      t = TOK_W'(c - 8'h57);
    end else begin
      case (c)
        8'h28:   t = TOK_LPAREN;
        8'h29:   t = TOK_RPAREN;
        8'h2a:   t = TOK_MUL;
        8'h2b:   t = TOK_ADD;
        8'h2d:   t = TOK_SUB;
        8'h3d:   t = TOK_EQ;
`ifdef AEC_DIV_EN
        8'h2f:   t = TOK_DIV;
`endif
        default: t = TOK_ILL;
      endcase
    end
    return t;
  endfunction

  function automatic logic [1:0] prec(input tok_t t);
    logic [1:0] p;
    p = 2'd0;
    if (t == TOK_MUL || t == TOK_DIV) p = 2'd2;
    else if (t == TOK_ADD || t == TOK_SUB) p = 2'd1;
    return p;
  endfunction

  function automatic logic is_digit(input tok_t t);
    return (t < TOK_LPAREN);
  endfunction

endpackage

// File: rtl/aec_param_if.sv
// Character-in / result-out handshake bundle of the expression calculator.
interface aec_param_if #(
  parameter int unsigned DATA_W = 7
);
  logic              ready;
  logic [7:0]        ascii_in;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] result;
  logic              error;

  modport master (
    output ready, ascii_in,
    input  busy, valid, result, error
  );

  modport slave (
    input  ready, ascii_in,
    output busy, valid, result, error
  );
endinterface

// File: rtl/aec_alu.sv
// Combinational binary operator for reduce steps; divider present only with AEC_DIV_EN.
module aec_alu
  import aec_pkg::*;
#(
  parameter int unsigned DATA_W = 7
) (
  input  tok_t              op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_c_o,
  output logic              div0_c_o
);

  always_comb begin
    y_c_o    = '0;
    div0_c_o = 1'b0;
    case (op_i)
      TOK_ADD: y_c_o = a_i + b_i;
      TOK_SUB: y_c_o = a_i - b_i;
      TOK_MUL: y_c_o = a_i * b_i;
`ifdef AEC_DIV_EN
      TOK_DIV: begin
        div0_c_o = (b_i == '0);
        y_c_o    = div0_c_o ? '0 : a_i / b_i;
      end
`endif
      default: y_c_o = '0;
    endcase
  end

endmodule

// File: rtl/aec_param.sv
// ASCII infix expression calculator: buffers tokens up to '=', then evaluates them
// with a one-action-per-cycle shunting-yard engine. Optional macro AEC_DIV_EN adds '/'.
module aec_param
  import aec_pkg::*;
#(
  parameter int unsigned DATA_W      = 7,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input logic        clk,
  input logic        rst,
  aec_param_if.slave bus
);

  localparam int unsigned WP_W = $clog2(MAX_LEN + 1);
  localparam int unsigned BI_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  state_e            state_q, state_d;
  logic [WP_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [WP_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SP_W-1:0]   vsp_q, vsp_d;
  logic [SP_W-1:0]   osp_q, osp_d;
  logic              lerr_q, lerr_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] result_q, result_d;

  tok_t              tbuf_q [MAX_LEN];
  logic [DATA_W-1:0] vals_q [STACK_DEPTH];
  tok_t              ops_q  [STACK_DEPTH];

  logic              accept;
  tok_t              tok_in;
  tok_t              tok_cur;
  tok_t              top_op;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] alu_y;
  logic              alu_div0;

  logic              buf_we;
  logic              val_we;
  logic [SI_W-1:0]   val_waddr;
  logic [DATA_W-1:0] val_wdata;
  logic              op_we;
  logic              reduce;
  logic              fail;
  logic              fin;
  logic              fin_err;

  assign accept  = bus.ready && !busy_q;
  assign tok_in  = encode(bus.ascii_in);
  assign tok_cur = tbuf_q[BI_W'(rd_ptr_q)];
  assign top_op  = ops_q[SI_W'(osp_q - SP_W'(1))];
  assign opnd_a  = vals_q[SI_W'(vsp_q - SP_W'(2))];
  assign opnd_b  = vals_q[SI_W'(vsp_q - SP_W'(1))];

  aec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i     (top_op),
    .a_i      (opnd_a),
    .b_i      (opnd_b),
    .y_c_o    (alu_y),
    .div0_c_o (alu_div0)
  );

  // Next-state, datapath control and output values
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    vsp_d     = vsp_q;
    osp_d     = osp_q;
    lerr_d    = lerr_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    error_d   = error_q;
    result_d  = result_q;
    buf_we    = 1'b0;
    val_we    = 1'b0;
    val_waddr = SI_W'(vsp_q);
    val_wdata = '0;
    op_we     = 1'b0;
    reduce    = 1'b0;
    fail      = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (tok_in == TOK_EQ) begin
            // '=' alone, or after a load-time error, skips evaluation
            if (state_q == S_IDLE || lerr_q) fail = 1'b1;
            else state_d = S_EVAL;
          end else begin
            state_d = S_LOAD;
            if (tok_in == TOK_ILL || wr_ptr_q == WP_W'(MAX_LEN)) begin
              lerr_d = 1'b1;
            end else begin
              buf_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + WP_W'(1);
            end
          end
        end
      end

      S_EVAL: begin
        if (rd_ptr_q != wr_ptr_q) begin
          if (is_digit(tok_cur)) begin
            if (vsp_q == SP_W'(STACK_DEPTH)) begin
              fail = 1'b1;
            end else begin
              val_we    = 1'b1;
              val_wdata = DATA_W'(tok_cur);
              vsp_d     = vsp_q + SP_W'(1);
              rd_ptr_d  = rd_ptr_q + WP_W'(1);
            end
          end else if (tok_cur == TOK_RPAREN) begin
            if (osp_q == '0) begin
              fail = 1'b1;
            end else if (top_op == TOK_LPAREN) begin
              osp_d    = osp_q - SP_W'(1);
              rd_ptr_d = rd_ptr_q + WP_W'(1);
            end else begin
              reduce = 1'b1;
            end
          end else if (tok_cur != TOK_LPAREN && osp_q != '0 &&
                       top_op != TOK_LPAREN && prec(top_op) >= prec(tok_cur)) begin
            reduce = 1'b1;
          end else if (osp_q == SP_W'(STACK_DEPTH)) begin
            fail = 1'b1;
          end else begin
            op_we    = 1'b1;
            osp_d    = osp_q + SP_W'(1);
            rd_ptr_d = rd_ptr_q + WP_W'(1);
          end
        end else if (osp_q != '0) begin
          if (top_op == TOK_LPAREN) fail = 1'b1;
          else reduce = 1'b1;
        end else if (vsp_q == SP_W'(1)) begin
          fin = 1'b1;
        end else begin
          fail = 1'b1;
        end

        // Reduce writes the result over operand a, popping one operand and one operator
        if (reduce) begin
          if (32'(vsp_q) < 32'd2 || alu_div0) begin
            fail = 1'b1;
          end else begin
            val_we    = 1'b1;
            val_waddr = SI_W'(vsp_q - SP_W'(2));
            val_wdata = alu_y;
            vsp_d     = vsp_q - SP_W'(1);
            osp_d     = osp_q - SP_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        vsp_d    = '0;
        osp_d    = '0;
        lerr_d   = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      fin     = 1'b1;
      fin_err = 1'b1;
    end

    if (fin) begin
      state_d  = S_DONE;
      valid_d  = 1'b1;
      error_d  = fin_err;
      result_d = fin_err ? '0 : opnd_b;
    end

    busy_d = (state_d == S_EVAL) || (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vsp_q    <= '0;
      osp_q    <= '0;
      lerr_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vsp_q    <= vsp_d;
      osp_q    <= osp_d;
      lerr_q   <= lerr_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  // Token buffer and stacks hold no state that matters while their pointers are zero
  always_ff @(posedge clk) begin
    if (buf_we) tbuf_q[BI_W'(wr_ptr_q)] <= tok_in;
    if (val_we) vals_q[val_waddr] <= val_wdata;
    if (op_we)  ops_q[SI_W'(osp_q)] <= tok_cur;
  end

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.error  = error_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_aec_param.sv
// Self-checking bench for aec_param: table of expressions with a result scoreboard,
// plus reset-abort sequences.
module tb_aec_param;

  localparam int unsigned DW = 7;
  localparam int          NV = 24;

  typedef struct packed {
    logic [159:0]  text;
    logic          err;
    logic [DW-1:0] res;
  } vec_t;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] res;
    logic [7:0]    ntok;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aec_param_if #(.DATA_W(DW)) bus ();

  aec_param #(
    .DATA_W      (DW),
    .MAX_LEN     (16),
    .STACK_DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [159:0] t, input logic e, input int r);
    vec_t v;
    v.text = t;
    v.err  = e;
    v.res  = DW'(r);
    return v;
  endfunction

  // Result monitor: pops the scoreboard on every valid pulse
  int   eval_cnt   = 0;
  logic prev_valid = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst) begin
      eval_cnt   = 0;
      prev_valid = 1'b0;
    end else begin
      if (bus.valid) begin
        chk("valid_one_cycle", int'(prev_valid), 0);
        if (sb.size() == 0) begin
          chk("unexpected_valid", int'(bus.valid), 0);
        end else begin
          me = sb.pop_front();
          chk("error", int'(bus.error), int'(me.err));
          chk("result", int'(bus.result), int'(me.res));
          chk("busy_in_done", int'(bus.busy), 1);
          chk("eval_latency_bound", int'(eval_cnt <= 3 * int'(me.ntok) + 2), 1);
        end
        eval_cnt = 0;
      end else if (bus.busy) begin
        eval_cnt++;
      end
      prev_valid = bus.valid;
    end
  end

  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", int'(bus.busy), 0);
    bus.ready    = 1'b1;
    bus.ascii_in = c;
    @(negedge clk);
    bus.ready = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      bus.ascii_in = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_text(input logic [159:0] t);
    logic [7:0] c;
    for (int i = 19; i >= 0; i--) begin
      c = t[i*8 +: 8];
      if (c != 8'h00) send_char(c);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t       e;
    int         n;
    int         waitc;
    logic [7:0] c;
    n = 0;
    for (int i = 19; i >= 0; i--) begin
      c = v.text[i*8 +: 8];
      if (c != 8'h00 && c != 8'h3d) n++;
    end
    e.err  = v.err;
    e.res  = v.res;
    e.ntok = 8'(n);
    sb.push_back(e);
    send_text(v.text);
    // Keep offering characters while busy; they must be ignored
    waitc = 0;
    while ((sb.size() != 0 || bus.busy) && waitc < 300) begin
      bus.ready    = bus.busy;
      bus.ascii_in = 8'h31;
      @(negedge clk);
      waitc++;
    end
    bus.ready = 1'b0;
    chk({name, "_drained"}, sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    repeat (2) @(negedge clk);
    chk({name, "_hold_result"}, int'(bus.result), int'(v.res));
    chk({name, "_hold_error"}, int'(bus.error), int'(v.err));
    chk({name, "_valid_low"}, int'(bus.valid), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ready    = 1'b0;
    bus.ascii_in = 8'h00;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_error", int'(bus.error), 0);
    chk("reset_result", int'(bus.result), 0);
    rst = 1'b1;
    @(negedge clk);

    vecs[0]  = mk("2+3*4=", 1'b0, 14);
    vecs[1]  = mk("(a-2)*3=", 1'b0, 24);
    vecs[2]  = mk("2-5=", 1'b0, 125);
    vecs[3]  = mk("f*f*f=", 1'b0, 47);
    vecs[4]  = mk("(1+2=", 1'b1, 0);
    vecs[5]  = mk("1+2)=", 1'b1, 0);
    vecs[6]  = mk("8/0=", 1'b1, 0);
`ifdef AEC_DIV_EN
    vecs[7]  = mk("9/2=", 1'b0, 4);
    vecs[8]  = mk("9/2*3=", 1'b0, 12);
`else
    vecs[7]  = mk("9/2=", 1'b1, 0);
    vecs[8]  = mk("9/2*3=", 1'b1, 0);
`endif
    vecs[9]  = mk("=", 1'b1, 0);
    vecs[10] = mk("7=", 1'b0, 7);
    vecs[11] = mk("2*(3+4)-5=", 1'b0, 9);
    vecs[12] = mk("8-3-2=", 1'b0, 3);
    vecs[13] = mk("9-2+4=", 1'b0, 11);
    vecs[14] = mk("23=", 1'b1, 0);
    vecs[15] = mk("1+g=", 1'b1, 0);
    vecs[16] = mk("1 +2=", 1'b1, 0);
    vecs[17] = mk("1+1+1+1+1+1+1+1=", 1'b0, 8);
    vecs[18] = mk("1+1+1+1+1+1+1+1+1=", 1'b1, 0);
    vecs[19] = mk("((((((7))))))=", 1'b0, 7);
    vecs[20] = mk("e*e+c*(b-3)=", 1'b0, 36);
    vecs[21] = mk("0-1*1=", 1'b0, 127);
    vecs[22] = mk("f-f-f=", 1'b0, 113);
    vecs[23] = mk("(2+3)*(4+1)=", 1'b0, 25);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while loading aborts the expression
    run_vec(mk("7=", 1'b0, 7), "pre_reset");
    send_text("3+");
    rst = 1'b0;
    @(negedge clk);
    chk("load_reset_busy", int'(bus.busy), 0);
    chk("load_reset_valid", int'(bus.valid), 0);
    chk("load_reset_error", int'(bus.error), 0);
    chk("load_reset_result", int'(bus.result), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_vec(mk("4=", 1'b0, 4), "after_load_reset");

    // Reset while evaluating aborts without a later valid pulse
    send_text("f*f*f=");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("eval_reset_busy", int'(bus.busy), 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("eval_reset_result", int'(bus.result), 0);
    run_vec(mk("5+5=", 1'b0, 10), "after_eval_reset");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aec_param.md
AEC_PARAM -- requirements
Module: aec_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 7: operand/result width; all arithmetic is modulo 2^DATA_W.
REQ-002 SHALL provide parameter MAX_LEN, default 16: token buffer depth, excluding '='.
REQ-003 SHALL provide parameter STACK_DEPTH, default 8: depth of both the operand stack and the operator stack.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ready  input  1  ascii_in qualifier; a character is accepted only when ready=1 and busy=0.
REQ-007 ascii_in  input  8  ASCII character stream.
REQ-008 busy  output  1  high while evaluating or presenting a result; input is ignored while high.
REQ-009 valid  output  1  one-cycle pulse marking result/error as valid.
REQ-010 result  output  DATA_W  expression value; 0 when error=1.
REQ-011 error  output  1  qualified by valid: the expression was rejected.

Function
REQ-012 Accepted characters: '0'-'9', 'a'-'f' (single-digit hex operands 0-15), '(', ')', '*', '+', '-', and '='; any other character is illegal.
REQ-013 States: IDLE, LOAD, EVAL, DONE.
- IDLE->LOAD on the first accepted character.
- LOAD->EVAL on the cycle after '=' is accepted.
- EVAL->DONE when the input is exhausted and the operator stack is empty, or on any error.
- DONE->IDLE after exactly one cycle.
REQ-014 In LOAD, each accepted character SHALL be encoded and written to buffer[wr_ptr], and wr_ptr SHALL increment; cycles with ready=0 SHALL leave the buffer and wr_ptr unchanged.
REQ-015 EVAL SHALL use shunting-yard evaluation, performing one push, reduce or pop action per cycle.
- Precedence: '*' above '+' and '-'.
- All operators are left-associative.
- Parentheses nest up to STACK_DEPTH.
REQ-016 A reduce SHALL pop two operands (a below b), apply the operator and push the result: a+b, a-b, a*b, each truncated to DATA_W bits; subtraction wraps.
REQ-017 EVAL latency SHALL NOT exceed 3*N+2 cycles for N buffered tokens.
REQ-018 busy SHALL be high in EVAL and DONE and low in IDLE and LOAD.
REQ-019 In DONE, valid=1 for exactly one cycle, with result equal to the single remaining operand and error=0.
REQ-020 Any error condition SHALL end evaluation, and in DONE present valid=1, error=1, result=0. Error conditions:
- illegal character;
- buffer overflow (an (MAX_LEN+1)th character before '=');
- either stack overflowing;
- ')' with no matching '(';
- '(' left open at end of input;
- operand count not equal to 1 at end of evaluation;
- '=' received as the first character.
REQ-021 LOAD SHALL continue to accept characters after an error is detected until '=' arrives, then proceed directly to DONE.
REQ-022 After DONE, the block SHALL return to IDLE with all pointers cleared, ready for the next expression with no gap cycle beyond DONE.
REQ-023 valid, error and result SHALL hold their values outside DONE until the next DONE.

Reset
REQ-024 When rst=0, the block SHALL asynchronously enter IDLE and clear valid, error, busy, result, wr_ptr, rd_ptr and both stack pointers; buffer contents need not be cleared.
REQ-025 Reset asserted mid-LOAD or mid-EVAL SHALL abort the expression; no valid pulse SHALL follow the release of reset.

Configuration
REQ-026 With AEC_DIV_EN defined:
- '/' (ASCII 47) SHALL be accepted at the same precedence as '*' and evaluate as unsigned a/b truncated toward zero;
- b=0 SHALL be an error.
REQ-027 Without AEC_DIV_EN, '/' SHALL be an illegal character and no divider SHALL be synthesised.

Structure
REQ-028 Package aec_pkg SHALL hold:
- the token encoding constants (digits 0-15, LPAREN=16, RPAREN=17, MUL=18, ADD=19, SUB=20, DIV=21, EQ=22, ILL=23);
- the state enum;
- the precedence function.
REQ-029 Sub-module aec_alu SHALL be combinational (op, a, b -> y, div0), parametrised by DATA_W, and contain the divider only under AEC_DIV_EN.

Verification
REQ-030 "2+3*4=" -> valid pulse, result=14, error=0.
REQ-031 "(a-2)*3=" -> result=24; "2-5=" -> result=125 (wrap, DATA_W=7).
REQ-032 "f*f*f=" with DATA_W=7 -> result=47 (3375 mod 128).
REQ-033 "(1+2=" -> error=1, result=0; "1+2)=" -> error=1.
REQ-034 "8/0=" -> error=1 under either setting; "9/2=" -> result=4 with AEC_DIV_EN.
REQ-035 Reset is asserted after "3+" is loaded; after release, "4=" is sent -> no spurious valid pulse, then result=4; ready is toggled low mid-expression -> no characters are lost or duplicated.
